uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter STOP_BITS, default 1, number of stop-bit cycles per frame (legal values 1 or 2).
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1, asynchronous, active-low reset.
REQ-004 SHALL have port req0_valid, input, 1, requester 0 has a byte to send.
REQ-005 SHALL have port req0_data, input, 8, requester 0 byte.
REQ-006 SHALL have port req0_ready, output, 1, one-cycle accept pulse to requester 0.
REQ-007 SHALL have ports req1_valid, req1_data and req1_ready, with the same directions, widths and meanings as requester 0.
REQ-008 SHALL have port par_en, input, 1, parity enable, sampled at grant.
REQ-009 SHALL have port par_typ, input, 1, parity type, 0 = even and 1 = odd, sampled at grant.
REQ-010 SHALL have port ser_done, input, 1, serializer has shifted its 8th bit.
REQ-011 SHALL have port ser_en, output, 1, serializer shift enable.
REQ-012 SHALL have port p_data, output, 8, latched byte driven to the serializer.
REQ-013 SHALL have port par_bit, output, 1, computed parity bit.
REQ-014 SHALL have port mux_sel, output, 2, line select: 00 start(0), 01 idle/stop(1), 10 serial data, 11 parity.
REQ-015 SHALL have port busy, output, 1, frame in progress.
REQ-016 SHALL have port grant_id, output, 1, requester owning the current frame.

Function
REQ-017 SHALL implement the states IDLE, START, DATA, PARITY and STOP, all registered.
REQ-018 SHALL arbitrate in IDLE when any reqN_valid=1: in that same cycle it pulses the winner's ready, latches p_data, grant_id, par_en and par_typ, and enters START on the next edge.
REQ-019 SHALL use round-robin arbitration: when both requesters are valid, it grants the one not granted last; a single valid requester always wins.
REQ-020 SHALL never assert req0_ready and req1_ready in the same cycle, and SHALL never assert a ready while its valid is 0.
REQ-021 In START, SHALL drive mux_sel=00 and busy=1 for exactly 1 cycle, then enter DATA.
REQ-022 In DATA, SHALL drive ser_en=1 and mux_sel=10, and SHALL leave DATA on the cycle after ser_done=1 is sampled.
REQ-023 SHALL go from DATA to PARITY if the latched par_en=1, otherwise to STOP.
REQ-024 SHALL set par_bit = XOR of p_data[7:0] for even parity, and its inverse for odd parity; it is computed at grant and held for the frame.
REQ-025 In PARITY, SHALL drive mux_sel=11 for 1 cycle, then enter STOP.
REQ-026 In STOP, SHALL drive mux_sel=01 for STOP_BITS cycles, using an internal counter.
REQ-027 In the last STOP cycle, if any valid=1, SHALL arbitrate exactly as in IDLE and go directly to START (back-to-back frames, no idle gap); otherwise it enters IDLE.
REQ-028 SHALL assert busy in START, DATA, PARITY and STOP, and deassert it in IDLE.
REQ-029 SHALL drive ser_en=0 in every state except DATA.
REQ-030 SHALL ignore ser_done outside DATA.
REQ-031 SHALL ignore changes to par_en, par_typ or reqN_data after grant until the next grant.
REQ-032 SHALL hold p_data stable from grant through the end of STOP.

Reset
REQ-033 On rst=0, SHALL asynchronously force state=IDLE, ser_en=0, mux_sel=01, busy=0, both readies=0, p_data=0, par_bit=0, grant_id=0, the stop counter=0, and the last-grant pointer to requester 1, so that requester 0 wins first.
REQ-034 Reset asserted mid-frame SHALL abort the frame; the aborted byte is not resent, and the line returns to idle (mux_sel=01) immediately.
REQ-035 After rst is released, SHALL start its first arbitration on the first rising edge with rst=1.

Verification
REQ-036 Stimulus: req0 sends 0xA5, par_en=1, par_typ=0, serializer model raises ser_done after 8 ser_en cycles -> required: mux_sel sequence 00, 10x8, 11, 01; par_bit=0; req0_ready pulses once.
REQ-037 Stimulus: same as REQ-036 with par_typ=1 and data 0x01 -> required: par_bit=0; with par_en=0 -> required: no 11 cycle, DATA goes straight to STOP.
REQ-038 Stimulus: req0 and req1 held valid continuously -> required: grants alternate 0,1,0,1; frames back-to-back with no IDLE cycle; readies are mutually exclusive.
REQ-039 Stimulus: STOP_BITS=2 -> required: two 01 cycles per frame, and busy stays 1 through both.
REQ-040 Stimulus: rst pulsed low during DATA -> required: ser_en=0, mux_sel=01 and busy=0 the same cycle; the next grant goes to req0.
REQ-041 Stimulus: ser_done pulsed during IDLE or STOP, and req0_data changed mid-frame -> required: no state change, and p_data unchanged.

Source files
------------

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: round-robin arbitration between two byte requesters and
// frame sequencing (start, 8 data bits via external serializer, optional parity, stop).
module uart_tx_sched #(
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  input  logic       par_en,
  input  logic       par_typ,
  input  logic       ser_done,
  output logic       ser_en,
  output logic [7:0] p_data,
  output logic       par_bit,
  output logic [1:0] mux_sel,
  output logic       busy,
  output logic       grant_id
);

  localparam logic [1:0] SelStart = 2'b00;
  localparam logic [1:0] SelIdle  = 2'b01;
  localparam logic [1:0] SelData  = 2'b10;
  localparam logic [1:0] SelPar   = 2'b11;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e     state_q;
  logic [1:0] stop_cnt_q;
  logic       last_q;
  logic       par_en_q;
  logic       ser_en_q;
  logic       busy_q;
  logic       par_bit_q;
  logic       grant_id_q;
  logic [1:0] mux_sel_q;
  logic [7:0] p_data_q;

  logic       last_stop;
  logic       arb_win;
  logic       pick;
  logic       grant;
  logic [7:0] grant_data;

  // Arbitration window, round-robin winner and the grant strobe (gated off during reset).
  always_comb begin
    last_stop  = (state_q == StStop) && (stop_cnt_q == 2'(STOP_BITS - 1));
    arb_win    = (state_q == StIdle) || last_stop;
    pick       = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    grant      = arb_win && (req0_valid || req1_valid) && rst;
    grant_data = pick ? req1_data : req0_data;
  end

  assign req0_ready = grant & ~pick;
  assign req1_ready = grant & pick;
  assign ser_en     = ser_en_q;
  assign p_data     = p_data_q;
  assign par_bit    = par_bit_q;
  assign mux_sel    = mux_sel_q;
  assign busy       = busy_q;
  assign grant_id   = grant_id_q;

  // Frame sequencer with registered line-control outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      stop_cnt_q <= 2'd0;
      last_q     <= 1'b1;
      par_en_q   <= 1'b0;
      ser_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      par_bit_q  <= 1'b0;
      grant_id_q <= 1'b0;
      mux_sel_q  <= SelIdle;
      p_data_q   <= 8'h00;
    end else if (grant) begin
      // Grant from IDLE or the last stop cycle: latch the frame and go to START.
      state_q    <= StStart;
      stop_cnt_q <= 2'd0;
      last_q     <= pick;
      grant_id_q <= pick;
      p_data_q   <= grant_data;
      par_en_q   <= par_en;
      par_bit_q  <= (^grant_data) ^ par_typ;
      ser_en_q   <= 1'b0;
      busy_q     <= 1'b1;
      mux_sel_q  <= SelStart;
    end else begin
      case (state_q)
        StIdle: begin
          busy_q    <= 1'b0;
          ser_en_q  <= 1'b0;
          mux_sel_q <= SelIdle;
        end
        StStart: begin
          state_q   <= StData;
          ser_en_q  <= 1'b1;
          mux_sel_q <= SelData;
        end
        StData: begin
          if (ser_done) begin
            ser_en_q   <= 1'b0;
            stop_cnt_q <= 2'd0;
            if (par_en_q) begin
              state_q   <= StParity;
              mux_sel_q <= SelPar;
            end else begin
              state_q   <= StStop;
              mux_sel_q <= SelIdle;
            end
          end
        end
        StParity: begin
          state_q    <= StStop;
          stop_cnt_q <= 2'd0;
          mux_sel_q  <= SelIdle;
        end
        StStop: begin
          if (last_stop) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            stop_cnt_q <= stop_cnt_q + 2'd1;
          end
        end
        default: begin
          state_q   <= StIdle;
          busy_q    <= 1'b0;
          ser_en_q  <= 1'b0;
          mux_sel_q <= SelIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized bench for uart_tx_sched: two instances (1 and 2 stop bits) checked against a
// frame-level reference model (frame position/length arithmetic plus round-robin rule).
module tb_uart_tx_sched;

  localparam int NumCycles = 2400;

  logic       clk;
  logic       rst;
  logic       req0_valid [2];
  logic [7:0] req0_data  [2];
  logic       req0_ready [2];
  logic       req1_valid [2];
  logic [7:0] req1_data  [2];
  logic       req1_ready [2];
  logic       par_en     [2];
  logic       par_typ    [2];
  logic       ser_done   [2];
  logic       ser_en     [2];
  logic [7:0] p_data     [2];
  logic       par_bit    [2];
  logic [1:0] mux_sel    [2];
  logic       busy       [2];
  logic       grant_id   [2];

  uart_tx_sched #(.STOP_BITS(1)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid[0]),
    .req0_data (req0_data[0]),
    .req0_ready(req0_ready[0]),
    .req1_valid(req1_valid[0]),
    .req1_data (req1_data[0]),
    .req1_ready(req1_ready[0]),
    .par_en    (par_en[0]),
    .par_typ   (par_typ[0]),
    .ser_done  (ser_done[0]),
    .ser_en    (ser_en[0]),
    .p_data    (p_data[0]),
    .par_bit   (par_bit[0]),
    .mux_sel   (mux_sel[0]),
    .busy      (busy[0]),
    .grant_id  (grant_id[0])
  );

  uart_tx_sched #(.STOP_BITS(2)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid[1]),
    .req0_data (req0_data[1]),
    .req0_ready(req0_ready[1]),
    .req1_valid(req1_valid[1]),
    .req1_data (req1_data[1]),
    .req1_ready(req1_ready[1]),
    .par_en    (par_en[1]),
    .par_typ   (par_typ[1]),
    .ser_done  (ser_done[1]),
    .ser_en    (ser_en[1]),
    .p_data    (p_data[1]),
    .par_bit   (par_bit[1]),
    .mux_sel   (mux_sel[1]),
    .busy      (busy[1]),
    .grant_id  (grant_id[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state, per instance.
  int         pos    [2];  // cycle index within current frame, -1 when idle
  int         flen   [2];  // frame length in cycles
  logic       m_last [2];
  logic [7:0] m_data [2];
  logic       m_par  [2];
  logic       m_pe   [2];
  logic       m_gid  [2];
  int         sercnt [2];
  logic       hold   [2][2];
  int         grants [2];
  int         par_frames [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      pos[d]    = -1;
      flen[d]   = 0;
      m_last[d] = 1'b1;
      sercnt[d] = 0;
    end
  endtask

  task automatic drive(input int d, input bit cont);
    if (!hold[d][0]) hold[d][0] = cont ? 1'b1 : ($urandom_range(3) == 0);
    if (!hold[d][1]) hold[d][1] = cont ? 1'b1 : ($urandom_range(3) == 0);
    req0_valid[d] = hold[d][0];
    req1_valid[d] = hold[d][1];
    req0_data[d]  = 8'($urandom_range(255));
    req1_data[d]  = 8'($urandom_range(255));
    par_en[d]     = 1'($urandom_range(1));
    par_typ[d]    = 1'($urandom_range(1));
    // Serializer: done after its 8th enabled cycle; stray pulses while disabled.
    if (ser_en[d] === 1'b1) begin
      ser_done[d] = (sercnt[d] == 7);
      sercnt[d]   = ser_done[d] ? 0 : sercnt[d] + 1;
    end else begin
      ser_done[d] = ($urandom_range(3) == 0);
    end
  endtask

  task automatic check_out(input int d);
    logic [1:0] e_mux;
    logic       e_busy;
    logic       e_sen;
    if (pos[d] < 0) begin
      e_mux = 2'b01; e_busy = 1'b0; e_sen = 1'b0;
    end else begin
      e_busy = 1'b1;
      e_sen  = (pos[d] >= 1 && pos[d] <= 8);
      if (pos[d] == 0) e_mux = 2'b00;
      else if (pos[d] <= 8) e_mux = 2'b10;
      else if (pos[d] == 9 && m_pe[d]) e_mux = 2'b11;
      else e_mux = 2'b01;
    end
    check($sformatf("d%0d_mux_sel", d), 32'(mux_sel[d]), 32'(e_mux));
    check($sformatf("d%0d_busy", d), 32'(busy[d]), 32'(e_busy));
    check($sformatf("d%0d_ser_en", d), 32'(ser_en[d]), 32'(e_sen));
    if (pos[d] >= 0) begin
      check($sformatf("d%0d_p_data", d), 32'(p_data[d]), 32'(m_data[d]));
      check($sformatf("d%0d_par_bit", d), 32'(par_bit[d]), 32'(m_par[d]));
      check($sformatf("d%0d_grant_id", d), 32'(grant_id[d]), 32'(m_gid[d]));
    end
  endtask

  task automatic check_ready_update(input int d);
    logic v0, v1, win, g, pk;
    v0  = req0_valid[d];
    v1  = req1_valid[d];
    win = (pos[d] < 0) || (pos[d] == flen[d] - 1);
    pk  = (v0 && v1) ? !m_last[d] : v1;
    g   = win && (v0 || v1);
    check($sformatf("d%0d_req0_ready", d), 32'(req0_ready[d]), 32'(g && !pk));
    check($sformatf("d%0d_req1_ready", d), 32'(req1_ready[d]), 32'(g && pk));
    if (g) begin
      m_data[d] = pk ? req1_data[d] : req0_data[d];
      m_pe[d]   = par_en[d];
      m_par[d]  = (^m_data[d]) ^ par_typ[d];
      m_gid[d]  = pk;
      m_last[d] = pk;
      flen[d]   = 9 + (par_en[d] ? 1 : 0) + (d + 1);
      pos[d]    = 0;
      hold[d][pk] = 1'b0;
      grants[d]++;
      if (par_en[d]) par_frames[d]++;
    end else if (pos[d] >= 0) begin
      pos[d]++;
      if (pos[d] >= flen[d]) pos[d] = -1;
    end
  endtask

  initial begin
    int rsts = 0;
    bit cont;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req0_valid[d] = 1'b1; req1_valid[d] = 1'b1;
      req0_data[d]  = 8'h5A; req1_data[d] = 8'hC3;
      par_en[d] = 1'b1; par_typ[d] = 1'b1; ser_done[d] = 1'b1;
      hold[d][0] = 1'b0; hold[d][1] = 1'b0;
      grants[d] = 0; par_frames[d] = 0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    // Reset values, with both requesters valid: no ready may fire while in reset.
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_rst_mux_sel", d), 32'(mux_sel[d]), 32'h1);
      check($sformatf("d%0d_rst_busy", d), 32'(busy[d]), 32'h0);
      check($sformatf("d%0d_rst_ser_en", d), 32'(ser_en[d]), 32'h0);
      check($sformatf("d%0d_rst_p_data", d), 32'(p_data[d]), 32'h0);
      check($sformatf("d%0d_rst_par_bit", d), 32'(par_bit[d]), 32'h0);
      check($sformatf("d%0d_rst_grant_id", d), 32'(grant_id[d]), 32'h0);
      check($sformatf("d%0d_rst_req0_ready", d), 32'(req0_ready[d]), 32'h0);
      check($sformatf("d%0d_rst_req1_ready", d), 32'(req1_ready[d]), 32'h0);
      req0_valid[d] = 1'b0; req1_valid[d] = 1'b0; ser_done[d] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;

    for (int cyc = 0; cyc < NumCycles; cyc++) begin
      @(posedge clk);
      #1;
      cont = ((cyc / 400) % 2) == 1;
      for (int d = 0; d < 2; d++) drive(d, cont);
      #1;
      for (int d = 0; d < 2; d++) check_out(d);
      // Abort a frame mid-DATA with an asynchronous reset, released on the falling edge.
      if (rsts < 2 && cyc > 700 * (rsts + 1) && pos[0] >= 2 && pos[0] <= 6) begin
        rsts++;
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
          check($sformatf("d%0d_abort_ser_en", d), 32'(ser_en[d]), 32'h0);
          check($sformatf("d%0d_abort_mux_sel", d), 32'(mux_sel[d]), 32'h1);
          check($sformatf("d%0d_abort_busy", d), 32'(busy[d]), 32'h0);
          check($sformatf("d%0d_abort_p_data", d), 32'(p_data[d]), 32'h0);
          check($sformatf("d%0d_abort_ready", d), 32'(req0_ready[d] | req1_ready[d]), 32'h0);
        end
        model_reset();
        #2;
        rst = 1'b1;
        #1;
      end
      for (int d = 0; d < 2; d++) check_ready_update(d);
    end

    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_enough_grants", d), 32'(grants[d] > 60), 32'h1);
      check($sformatf("d%0d_parity_frames", d), 32'(par_frames[d] > 10), 32'h1);
    end
    check("mid_frame_resets", 32'(rsts), 32'd2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
